periph_reg_block: RTL
=====================

// Module: periph_reg_block
// PURPOSE
//  Register block sitting directly downstream of bus_adapter.
//  Consumes the regiser_block_io.in modport: decodes wr/rd strobes into a small CSR map.
//  Hosts a compare timer with a sticky hit status, and returns registered read data.
// PARAMETERS
//  ADDR_W    4             word-index width; the interface addr is ADDR_W+1 bits, and only addr[ADDR_W-1:0] is decoded
//  ID_VALUE  32'h5045_0001 constant returned by the ID register
// PORTS
//  clk             in   1         single clock, all logic rising-edge
//  reset           in   1         synchronous, active-high
//  reg_io.wr       in   1         write strobe, one access per cycle
//  reg_io.rd       in   1         read strobe
//  reg_io.addr     in   ADDR_W+1  word index
//  reg_io.data_i   in   32        write data
//  reg_io.data_o   out  32        read data (registered)
//  irq             out  1         timer interrupt (only with PERIPH_IRQ_EN)
// BEHAVIOUR
//  Register map (word index):
//   0 ID      RO    ID_VALUE
//   1 CTRL    RW    [0] en, [1] auto_reload, [2] irq_en; upper bits read 0
//   2 STATUS  RW1C  [0] hit, [1] ovf (hit arrived while hit still set)
//   3 LOAD    RW    32-bit compare value
//   4 COUNT   RO    current count; any write clears it to 0
//   5..max    unmapped: reads 0, writes ignored
//  Reset: CTRL, STATUS, LOAD, COUNT, data_o and irq are all 0.
//  Read:
//   - rd in cycle N -> data_o valid in cycle N+1
//   - data_o holds its value until the next rd
//   - wr and rd together: both execute; rd returns the pre-write value
//  Timer, while CTRL.en=1:
//   - COUNT==LOAD -> hit_pulse; STATUS.hit<=1; STATUS.ovf<=1 if hit was already 1
//   - on hit_pulse: auto_reload=1 -> COUNT<=0; auto_reload=0 -> COUNT holds, CTRL.en<=0
//   - otherwise COUNT<=COUNT+1, modulo 2^32
//   - LOAD=0 with auto_reload -> hit every cycle
//  While CTRL.en=0, COUNT holds its value.
//  Simultaneous events:
//   - STATUS W1C and hit_pulse in the same cycle: set wins
//   - CTRL write and HW en-clear: SW write wins
//   - COUNT write and increment/reload: write wins (0)
//   - LOAD write takes effect for the compare of the following cycle
//  Reset asserted mid-count overrides everything: all state returns to reset values next edge.
// CONFIGURATION
//  PERIPH_IRQ_EN defined:
//   - irq registered
//   - irq = CTRL.irq_en & STATUS.hit, asserted 1 cycle after the condition
//   - deasserted 1 cycle after the W1C clear
//  PERIPH_IRQ_EN undefined:
//   - irq tied to 0
//   - CTRL[2] reads 0 and is not writable
// STRUCTURE
//  Package periph_reg_pkg:
//   - reg_addr_e enum (ID, CTRL, STATUS, LOAD, COUNT)
//   - ctrl_t packed struct and STATUS bit-position constants
//   - ID default constant
//  Sub-module periph_timer:
//   - inputs: en, auto_reload, load, clr
//   - outputs: count, hit_pulse, en_clr
//  Top level: address decode, CSR flops, read mux and data_o register.
// TESTING
//  1 Reset, then rd addr 0 -> data_o=32'h5045_0001 next cycle; rd addr 4 -> 0.
//  2 LOAD=3, CTRL=3 (en, auto_reload) -> hit every 4 cycles; STATUS reads 1, then 3 after the second hit with no clear.
//  3 LOAD=2, CTRL=1 -> one hit; COUNT holds 2; CTRL reads 0.
//  4 W1C STATUS=1 in the same cycle as hit_pulse -> STATUS.hit stays 1.
//  5 PERIPH_IRQ_EN, CTRL=7, LOAD=5 -> irq rises 1 cycle after hit; W1C STATUS=1 -> irq low 1 cycle later.
//  6 wr and rd to addr 3 together (old 5, new 9) -> data_o=5; the next rd returns 9; rd of addr 7 -> 0.

Source files
------------

// File: rtl/periph_reg_pkg.sv
// Shared definitions for the peripheral register block: register indices, CTRL layout,
// STATUS bit positions and the default ID word.
package periph_reg_pkg;

  localparam logic [31:0] ID_DEFAULT = 32'h5045_0001;

  typedef enum logic [2:0] {
    REG_ID     = 3'd0,
    REG_CTRL   = 3'd1,
    REG_STATUS = 3'd2,
    REG_LOAD   = 3'd3,
    REG_COUNT  = 3'd4
  } reg_addr_e;

  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic en;
  } ctrl_t;

  localparam int STATUS_HIT = 0;
  localparam int STATUS_OVF = 1;

endpackage

// File: rtl/regiser_block_io.sv
// Register access channel between bus_adapter (out side) and the register block (in side).
interface regiser_block_io #(
  parameter int ADDR_W = 4
);
  logic              wr;
  logic              rd;
  logic [ADDR_W:0]   addr;
  logic [31:0]       data_i;
  logic [31:0]       data_o;

  modport in  (input wr, rd, addr, data_i, output data_o);
  modport out (output wr, rd, addr, data_i, input data_o);
endinterface

// File: rtl/periph_timer.sv
// Compare timer: free-running counter that hits when it equals the compare value,
// then either reloads to zero or stops and requests the enable be cleared.
module periph_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        auto_reload,
  input  logic [31:0] load,
  input  logic        clr,
  output logic [31:0] count,
  output logic        hit_pulse,
  output logic        en_clr
);

  assign hit_pulse = en & (count == load);
  assign en_clr    = hit_pulse & ~auto_reload;

  // A software clear beats both reload and increment; one-shot mode holds on hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (hit_pulse) begin
      if (auto_reload) count <= '0;
    end else if (en) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/periph_reg_block.sv
// CSR block behind bus_adapter: ID/CTRL/STATUS/LOAD/COUNT map, compare timer, registered reads.
// Optional timer interrupt output enabled by defining PERIPH_IRQ_EN.
module periph_reg_block
  import periph_reg_pkg::*;
#(
  parameter int          ADDR_W   = 4,
  parameter logic [31:0] ID_VALUE = ID_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  regiser_block_io.in     reg_io,
  output logic            irq
);

`ifdef PERIPH_IRQ_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

  ctrl_t              ctrl;
  logic               hit;
  logic               ovf;
  logic [31:0]        load;
  logic [31:0]        count;
  logic [31:0]        rd_data;
  logic [31:0]        data_q;
  logic               hit_pulse;
  logic               en_clr;
  logic [ADDR_W-1:0]  idx;
  logic               unused_addr_msb;
  logic               wr_ctrl, wr_status, wr_load, wr_count;

  function automatic logic sel(input logic [ADDR_W-1:0] a, input reg_addr_e r);
    return a == ADDR_W'(r);
  endfunction

  assign idx             = reg_io.addr[ADDR_W-1:0];
  assign unused_addr_msb = reg_io.addr[ADDR_W];

  assign wr_ctrl   = reg_io.wr & sel(idx, REG_CTRL);
  assign wr_status = reg_io.wr & sel(idx, REG_STATUS);
  assign wr_load   = reg_io.wr & sel(idx, REG_LOAD);
  assign wr_count  = reg_io.wr & sel(idx, REG_COUNT);

  periph_timer u_timer (
    .clk         (clk),
    .reset       (reset),
    .en          (ctrl.en),
    .auto_reload (ctrl.auto_reload),
    .load        (load),
    .clr         (wr_count),
    .count       (count),
    .hit_pulse   (hit_pulse),
    .en_clr      (en_clr)
  );

  // Software CTRL writes take priority over the one-shot hardware enable clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= '0;
    end else if (wr_ctrl) begin
      ctrl <= ctrl_t'(reg_io.data_i[2:0] & CTRL_MASK);
    end else if (en_clr) begin
      ctrl.en <= 1'b0;
    end
  end

  // W1C with hardware set winning; ovf flags a hit landing on an already-set hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit <= 1'b0;
      ovf <= 1'b0;
    end else begin
      hit <= (hit & ~(wr_status & reg_io.data_i[STATUS_HIT])) | hit_pulse;
      ovf <= (ovf & ~(wr_status & reg_io.data_i[STATUS_OVF])) | (hit_pulse & hit);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        load <= '0;
    else if (wr_load) load <= reg_io.data_i;
  end

  always_comb begin
    rd_data = '0;
    if (sel(idx, REG_ID))          rd_data = ID_VALUE;
    else if (sel(idx, REG_CTRL))   rd_data = 32'(ctrl);
    else if (sel(idx, REG_STATUS)) rd_data = 32'({ovf, hit});
    else if (sel(idx, REG_LOAD))   rd_data = load;
    else if (sel(idx, REG_COUNT))  rd_data = count;
  end

  // Read data is taken from pre-edge state, so a same-cycle write is not visible yet.
  always_ff @(posedge clk) begin
    if (reset)          data_q <= '0;
    else if (reg_io.rd) data_q <= rd_data;
  end

  assign reg_io.data_o = data_q;

`ifdef PERIPH_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= ctrl.irq_en & hit;
  end
`else
  assign irq = 1'b0;
`endif

endmodule
